// File: rtl/arcade_input_ctrl_if.sv
// ioctl download bus from hps_io into the arcade input front end.
// hps_io drives it (master) and arcade_input_ctrl samples it (slave).
interface arcade_input_ctrl_if;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (output ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
  modport slave  (input  ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/arcade_input_ctrl.sv
// Registered player-input front end: PS/2 + joystick merge, coin pulse stretching,
// fire1 autofire, and DIP / mod byte capture from the ioctl download stream.
module arcade_input_ctrl #(
  parameter int          NPLAYERS    = 2,
  parameter int          NDIP        = 8,
  parameter logic [23:0] COIN_CYCLES = 24'd600000,
  parameter logic [23:0] AF_HALF     = 24'd400000
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [10:0]             ps2_key,
  input  logic [16*NPLAYERS-1:0]  joystick,
  input  logic                    joy_share,
  input  logic [NPLAYERS-1:0]     autofire,
  arcade_input_ctrl_if.slave      ioctl,
  output logic [8*NPLAYERS-1:0]   buttons,
  output logic [8*NDIP-1:0]       dipsw,
  output logic [7:0]              mod,
  output logic                    mod_valid
);

  localparam int B_R     = 0;
  localparam int B_L     = 1;
  localparam int B_D     = 2;
  localparam int B_U     = 3;
  localparam int B_FIRE1 = 4;
  localparam int B_FIRE2 = 5;
  localparam int B_START = 6;
  localparam int B_COIN  = 7;

  localparam int NKEY = (NPLAYERS > 1) ? 2 : 1;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_HOLD
  } coin_state_e;

  // ---------------------------------------------------------------------------
  // PS/2 keyboard decode
  // ---------------------------------------------------------------------------
  logic       ps2_toggle_q;
  logic       ps2_event;
  logic [7:0] key_q   [NKEY];
  logic [7:0] key_hit [2];

  assign ps2_event = ps2_key[10] != ps2_toggle_q;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    key_hit[0] = '0;
    key_hit[1] = '0;
    // Arrow keys arrive with or without the E0 prefix depending on the keyboard.
    case (ps2_key[7:0])
      8'h75:   key_hit[0][B_U] = 1'b1;
      8'h72:   key_hit[0][B_D] = 1'b1;
      8'h6B:   key_hit[0][B_L] = 1'b1;
      8'h74:   key_hit[0][B_R] = 1'b1;
      default: ;
    endcase
    if (!ps2_key[8]) begin
      case (ps2_key[7:0])
        8'h29:        key_hit[0][B_FIRE1] = 1'b1;
        8'h14:        key_hit[0][B_FIRE2] = 1'b1;
        8'h05, 8'h16: key_hit[0][B_START] = 1'b1;
        8'h2E:        key_hit[0][B_COIN]  = 1'b1;
        8'h2D:        key_hit[1][B_U]     = 1'b1;
        8'h2B:        key_hit[1][B_D]     = 1'b1;
        8'h23:        key_hit[1][B_L]     = 1'b1;
        8'h34:        key_hit[1][B_R]     = 1'b1;
        8'h1C:        key_hit[1][B_FIRE1] = 1'b1;
        8'h06, 8'h1E: key_hit[1][B_START] = 1'b1;
        8'h36:        key_hit[1][B_COIN]  = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_sys) begin
    ps2_toggle_q <= ps2_key[10];
    if (reset) begin
      for (int k = 0; k < NKEY; k++) key_q[k] <= '0;
    end else if (ps2_event) begin
      for (int k = 0; k < NKEY; k++)
        key_q[k] <= (key_q[k] & ~key_hit[k]) | (key_hit[k] & {8{ps2_key[9]}});
    end
  end

  // ---------------------------------------------------------------------------
  // Joystick merge
  // ---------------------------------------------------------------------------
  logic [7:0]            joy_or;
  logic [8*NPLAYERS-1:0] unused_joy_hi;

  always_comb begin
    joy_or        = '0;
    unused_joy_hi = '0;
    for (int p = 0; p < NPLAYERS; p++) begin
      joy_or |= joystick[16*p +: 8];
      unused_joy_hi[8*p +: 8] = joystick[16*p+8 +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Per-player button path
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
    logic [7:0]  key_p;
    logic [7:0]  raw;
    logic        coin_raw_q;
    coin_state_e state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] af_cnt_q;
    logic        af_phase_q;
    logic        fire_d;
    logic [6:0]  btn_q;

    if (p < NKEY) begin : g_key
      assign key_p = key_q[p];
    end else begin : g_nokey
      assign key_p = '0;
    end

    assign raw = key_p | (joy_share ? joy_or : joystick[16*p +: 8]);

    // Coin stretcher: COIN_CYCLES high, then COIN_CYCLES of lockout.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        COIN_IDLE: begin
          if (raw[B_COIN] && !coin_raw_q) begin
            state_d = COIN_PULSE;
            cnt_d   = COIN_CYCLES - 24'd1;
          end
        end
        COIN_PULSE: begin
          if (cnt_q == '0) begin
            state_d = COIN_HOLD;
            cnt_d   = COIN_CYCLES - 24'd1;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        COIN_HOLD: begin
          if (cnt_q == '0) state_d = COIN_IDLE;
          else             cnt_d   = cnt_q - 24'd1;
        end
        default: state_d = COIN_IDLE;
      endcase
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        state_q    <= COIN_IDLE;
        cnt_q      <= '0;
        coin_raw_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        coin_raw_q <= raw[B_COIN];
      end
    end

    // Phase 0 means "fire high", so a fresh press always starts with a shot.
    assign fire_d = raw[B_FIRE1] & ~(autofire[p] & af_phase_q);

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        af_cnt_q   <= '0;
        af_phase_q <= 1'b0;
        btn_q      <= '0;
      end else begin
        if (autofire[p] && raw[B_FIRE1]) begin
          if (af_cnt_q == AF_HALF - 24'd1) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
          end else begin
            af_cnt_q <= af_cnt_q + 24'd1;
          end
        end else begin
          af_cnt_q   <= '0;
          af_phase_q <= 1'b0;
        end
        btn_q <= {raw[B_START], raw[B_FIRE2], fire_d, raw[B_U:B_R]};
      end
    end

    assign buttons[8*p +: 8] = {state_q == COIN_PULSE, btn_q};
  end

  // ---------------------------------------------------------------------------
  // DIP switch and mod byte capture
  // ---------------------------------------------------------------------------
  // NOTE: these registers are deliberately left out of reset; they carry downloaded
  // settings across user resets and rely on the power-up value instead.
  logic [8*NDIP-1:0] dip_q       = '0;
  logic [7:0]        mod_q       = '0;
  logic              mod_valid_q = 1'b0;

  always_ff @(posedge clk_sys) begin
    if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'd254 && ioctl.ioctl_addr[24:3] == '0) begin
      for (int i = 0; i < NDIP; i++)
        if (ioctl.ioctl_addr[2:0] == 3'(i)) dip_q[8*i +: 8] <= ioctl.ioctl_dout;
    end
    if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'd1) begin
      mod_q       <= ioctl.ioctl_dout;
      mod_valid_q <= 1'b1;
    end
  end

  assign dipsw     = dip_q;
  assign mod       = mod_q;
  assign mod_valid = mod_valid_q;

endmodule
